// File: rtl/wb_cmd_master_if.sv
// Bundles the command/response streams and the Wishbone master-side bus of wb_cmd_master.
// The master modport is the master's own view. The slave modport is the view of the environment around it.
interface wb_cmd_master_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADR_WIDTH-1:0] cmd_adr_i;
  logic [DAT_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0] cmd_sel_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DAT_WIDTH-1:0] rsp_dat_o;
  logic [1:0]           rsp_status_o;

  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0] sel_o;
  logic                 tga_o;
  logic                 tgc_o;
  logic                 tgd_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, tga_o, tgc_o, tgd_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, tga_o, tgc_o, tgd_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: one valid/ready command becomes one bus cycle, with bounded
// retry and a no-answer timeout, and the outcome is returned on a valid/ready response stream.
module wb_cmd_master #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  wb_cmd_master_if.master     bus
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

  state_t               state, state_nxt;
  logic                 cmd_ready, cmd_ready_nxt;
  logic                 rsp_valid, rsp_valid_nxt;
  logic [DAT_WIDTH-1:0] rsp_dat, rsp_dat_nxt;
  logic [1:0]           rsp_status, rsp_status_nxt;
  logic                 cyc, cyc_nxt;
  logic                 we, we_nxt;
  logic [ADR_WIDTH-1:0] adr, adr_nxt;
  logic [DAT_WIDTH-1:0] dat, dat_nxt;
  logic [SEL_WIDTH-1:0] sel, sel_nxt;
  logic [RETRY_W-1:0]   retry_cnt, retry_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
  logic                 accept;

  assign accept = (state == IDLE) && cmd_ready && bus.cmd_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      cyc        <= 1'b0;
      we         <= 1'b0;
      adr        <= '0;
      dat        <= '0;
      sel        <= '0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cmd_ready  <= cmd_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_dat    <= rsp_dat_nxt;
      rsp_status <= rsp_status_nxt;
      cyc        <= cyc_nxt;
      we         <= we_nxt;
      adr        <= adr_nxt;
      dat        <= dat_nxt;
      sel        <= sel_nxt;
      retry_cnt  <= retry_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

  // Terminations are only looked at in BUS; outside it the intercon may leave them floating.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUS;
      BUS: begin
        if (bus.err_i || bus.ack_i)         state_nxt = RESP;
        else if (bus.rty_i)                 state_nxt = (retry_cnt == RETRY_LAST) ? RESP : BACKOFF;
        else if (tmo_cnt == TMO_LAST)       state_nxt = RESP;
      end
      BACKOFF: state_nxt = BUS;
      RESP:    if (bus.rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_nxt  = (state == IDLE) && !accept;
    rsp_valid_nxt  = (state_nxt == RESP);
    cyc_nxt        = (state_nxt == BUS);
    rsp_dat_nxt    = rsp_dat;
    rsp_status_nxt = rsp_status;
    we_nxt         = we;
    adr_nxt        = adr;
    dat_nxt        = dat;
    sel_nxt        = sel;
    retry_nxt      = retry_cnt;
    tmo_nxt        = tmo_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          we_nxt    = bus.cmd_we_i;
          adr_nxt   = bus.cmd_adr_i;
          dat_nxt   = bus.cmd_dat_i;
          sel_nxt   = bus.cmd_sel_i;
          retry_nxt = '0;
          tmo_nxt   = '0;
        end
      end
      // err beats ack beats rty; any termination in the last cycle beats the timeout
      BUS: begin
        if (bus.err_i) begin
          rsp_dat_nxt    = '0;
          rsp_status_nxt = ST_ERR;
        end else if (bus.ack_i) begin
          rsp_dat_nxt    = we ? '0 : bus.dat_i;
          rsp_status_nxt = ST_OK;
        end else if (bus.rty_i) begin
          if (retry_cnt == RETRY_LAST) begin
            rsp_dat_nxt    = '0;
            rsp_status_nxt = ST_RTY;
          end else begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            tmo_nxt   = '0;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_dat_nxt    = '0;
          rsp_status_nxt = ST_TMO;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_dat_o    = rsp_dat;
  assign bus.rsp_status_o = rsp_status;
  assign bus.cyc_o        = cyc;
  assign bus.stb_o        = cyc;
  assign bus.we_o         = we;
  assign bus.adr_o        = adr;
  assign bus.dat_o        = dat;
  assign bus.sel_o        = sel;
  assign bus.tga_o        = 1'b0;
  assign bus.tgc_o        = 1'b0;
  assign bus.tgd_o        = 1'b0;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: a scripted slave answers each bus attempt, and a
// transaction-level model predicts strobe lengths, backoff gaps, status and response data.
module tb_wb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MAXR = 3;
  localparam int TMO = 8;
  localparam int NTXN = 60;
  localparam int RESET_AT = 20;
  localparam int FOREVER_RTY = 99;

  typedef enum int {K_ACK, K_ERR, K_ACKERR, K_ACKRTY, K_ERRRTY, K_NONE} kind_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_cmd_master_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  wb_cmd_master #(
    .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .MAX_RETRY(MAXR), .TIMEOUT(TMO)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic          t_we;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_dat;
  logic [SW-1:0] t_sel;
  logic [DW-1:0] t_rdata;
  kind_t         t_kind;
  int            t_rty;
  int            t_wait;
  int            t_hold;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveTerms(input logic a, input logic e, input logic r, input logic [DW-1:0] d);
    bus.ack_i = a;
    bus.err_i = e;
    bus.rty_i = r;
    bus.dat_i = d;
  endtask

  // Outside BUS the termination lines carry junk, which the master must ignore.
  task automatic driveGarbage();
    driveTerms(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic driveCmd();
    bus.cmd_we_i    = t_we;
    bus.cmd_adr_i   = t_adr;
    bus.cmd_dat_i   = t_dat;
    bus.cmd_sel_i   = t_sel;
    bus.cmd_valid_i = 1'b1;
  endtask

  task automatic genTxn(input int idx);
    int r;
    t_we    = 1'($urandom_range(0, 1));
    t_adr   = $urandom;
    t_dat   = $urandom;
    t_sel   = 4'($urandom_range(0, 15));
    t_rdata = $urandom;
    t_kind  = kind_t'($urandom_range(0, 5));
    r = $urandom_range(0, 9);
    t_rty   = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, MAXR) : FOREVER_RTY;
    t_wait  = ($urandom_range(0, 5) == 0) ? TMO - 1 : $urandom_range(0, 2);
    t_hold  = $urandom_range(0, 5);
    case (idx)
      0: begin t_we = 0; t_adr = 32'h10; t_kind = K_ACK; t_rty = 0; t_wait = 2; t_rdata = 32'hDEADBEEF; t_hold = 0; end
      1: begin t_we = 1; t_adr = 32'h4; t_dat = 32'h12345678; t_sel = 4'hF; t_kind = K_ACK; t_rty = 0; t_wait = 0; t_hold = 0; end
      2: begin t_we = 0; t_kind = K_ACK; t_rty = 2; t_wait = 0; end
      3: begin t_we = 0; t_kind = K_ACK; t_rty = FOREVER_RTY; t_wait = 0; end
      4: begin t_we = 0; t_kind = K_NONE; t_rty = 0; end
      5: begin t_we = 0; t_kind = K_ACKERR; t_rty = 0; t_wait = 1; end
      6: begin t_we = 0; t_kind = K_ACK; t_rty = 0; t_wait = 0; t_hold = 5; end
      7: begin t_we = 0; t_kind = K_ACK; t_rty = 0; t_wait = TMO - 1; end
      8: begin t_we = 1; t_kind = K_NONE; t_rty = 1; t_wait = 3; end
      default: ;
    endcase
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    checkOutput("rst_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
    checkOutput("rst_rsp_status", 64'(bus.rsp_status_o), 64'd0);
    checkOutput("rst_cyc_stb_we", {61'd0, bus.cyc_o, bus.stb_o, bus.we_o}, 64'd0);
    checkOutput("rst_adr_dat_sel", {bus.adr_o, bus.dat_o | 32'(bus.sel_o)}, 64'd0);
    checkOutput("tags", {61'd0, bus.tga_o, bus.tgc_o, bus.tgd_o}, 64'd0);
  endtask

  task automatic applyStimulus(input int exp_ready_lat, input bit present_next, input int next_idx);
    int cnt, hi_cnt, gap_cnt, attempt, guard, c, exp_attempts, exp_len;
    bit was_high;
    logic [1:0] exp_status;
    logic [DW-1:0] exp_data;
    int high_lens[$];
    int gaps[$];

    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      driveGarbage();
      if (cnt == 1) begin
        bus.rsp_ready_i = 1'b0;
        checkOutput("rsp_valid_idle", 64'(bus.rsp_valid_o), 64'd0);
        checkOutput("cyc_before_accept", 64'(bus.cyc_o), 64'd0);
      end
    end while (!bus.cmd_ready_o && cnt < 20);
    checkOutput("cmd_ready_latency", 64'(cnt), 64'(exp_ready_lat));
    if (!bus.cmd_ready_o) return;

    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checkOutput("cmd_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    checkOutput("cyc_first", 64'(bus.cyc_o), 64'd1);
    was_high = 0; hi_cnt = 0; gap_cnt = 0; attempt = 0; guard = 0;
    while (guard < 200) begin
      if (bus.cyc_o) begin
        if (!was_high) begin
          if (attempt > 0) gaps.push_back(gap_cnt);
          gap_cnt = 0;
          checkOutput("adr_o", 64'(bus.adr_o), 64'(t_adr));
          checkOutput("dat_o", 64'(bus.dat_o), 64'(t_dat));
          checkOutput("sel_o", 64'(bus.sel_o), 64'(t_sel));
          checkOutput("we_o", 64'(bus.we_o), 64'(t_we));
          checkOutput("rsp_valid_in_bus", 64'(bus.rsp_valid_o), 64'd0);
        end
        checkOutput("stb_o", 64'(bus.stb_o), 64'd1);
        c = hi_cnt;
        hi_cnt++;
        was_high = 1;
        if (attempt < t_rty) driveTerms(1'b0, 1'b0, c == t_wait, $urandom);
        else if (c == t_wait) begin
          case (t_kind)
            K_ACK:    driveTerms(1'b1, 1'b0, 1'b0, t_rdata);
            K_ERR:    driveTerms(1'b0, 1'b1, 1'b0, t_rdata);
            K_ACKERR: driveTerms(1'b1, 1'b1, 1'b0, t_rdata);
            K_ACKRTY: driveTerms(1'b1, 1'b0, 1'b1, t_rdata);
            K_ERRRTY: driveTerms(1'b0, 1'b1, 1'b1, t_rdata);
            default:  driveTerms(1'b0, 1'b0, 1'b0, $urandom);
          endcase
        end else driveTerms(1'b0, 1'b0, 1'b0, $urandom);
      end else begin
        if (was_high) begin
          high_lens.push_back(hi_cnt);
          hi_cnt = 0;
          attempt++;
          was_high = 0;
        end
        if (bus.rsp_valid_o) break;
        gap_cnt++;
        driveGarbage();
      end
      @(negedge clk);
      guard++;
    end
    checkOutput("rsp_arrived", 64'(bus.rsp_valid_o), 64'd1);

    // Reference outcome from the transaction plan alone.
    exp_attempts = (t_rty > MAXR) ? MAXR + 1 : t_rty + 1;
    if (t_rty > MAXR)                                           exp_status = 2'b10;
    else if (t_kind == K_NONE)                                  exp_status = 2'b11;
    else if (t_kind == K_ERR || t_kind == K_ACKERR || t_kind == K_ERRRTY) exp_status = 2'b01;
    else                                                        exp_status = 2'b00;
    exp_data = (exp_status == 2'b00 && !t_we) ? t_rdata : '0;

    checkOutput("attempts", 64'(high_lens.size()), 64'(exp_attempts));
    foreach (high_lens[i]) begin
      exp_len = (i < t_rty || t_kind != K_NONE) ? t_wait + 1 : TMO;
      checkOutput("strobe_len", 64'(high_lens[i]), 64'(exp_len));
    end
    foreach (gaps[i]) checkOutput("backoff_gap", 64'(gaps[i]), 64'd1);
    checkOutput("rsp_status", 64'(bus.rsp_status_o), 64'(exp_status));
    checkOutput("rsp_dat", 64'(bus.rsp_dat_o), 64'(exp_data));
    checkOutput("cmd_ready_in_resp", 64'(bus.cmd_ready_o), 64'd0);

    for (int h = 0; h < t_hold; h++) begin
      @(negedge clk);
      driveGarbage();
      checkOutput("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      checkOutput("hold_status", 64'(bus.rsp_status_o), 64'(exp_status));
      checkOutput("hold_dat", 64'(bus.rsp_dat_o), 64'(exp_data));
      checkOutput("hold_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
      checkOutput("hold_cyc", 64'(bus.cyc_o), 64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    if (present_next) begin
      genTxn(next_idx);
      driveCmd();
    end
  endtask

  task automatic resetMidCycle();
    int cnt;
    t_we = 1'b0; t_adr = 32'h10; t_dat = '0; t_sel = 4'hF;
    driveCmd();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) bus.rsp_ready_i = 1'b0;
      driveGarbage();
    end while (!bus.cmd_ready_o && cnt < 20);
    checkOutput("mid_ready_latency", 64'(cnt), 64'd2);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    driveTerms(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_cyc1", 64'(bus.cyc_o), 64'd1);
    @(negedge clk);
    checkOutput("mid_cyc2", 64'(bus.cyc_o), 64'd1);
    rst_n = 1'b0;
    driveTerms(1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("mid_rst_cyc", 64'(bus.cyc_o), 64'd0);
    checkOutput("mid_rst_stb", 64'(bus.stb_o), 64'd0);
    checkOutput("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    repeat (2) begin
      @(negedge clk);
      driveGarbage();
    end
    checkResetValues();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    driveTerms(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      driveGarbage();
    end
    checkResetValues();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NTXN; i++) begin
      if (i == RESET_AT) resetMidCycle();
      if (i == 0 || i == RESET_AT) begin
        genTxn(i);
        driveCmd();
      end
      applyStimulus((i == 0 || i == RESET_AT) ? 1 : 2, (i + 1 < NTXN) && (i + 1 != RESET_AT), i + 1);
    end

    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
